// File: rtl/arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_pkg.sv
// Shared types for the BCAM MBIST return path: controller state and expectation-pipe stage.
// The stage width follows the default 144-entry array; the top's address width must match it.
package arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_pkg;

    localparam int CM_ENTRIES = 144;
    localparam int CM_AWIDTH  = $clog2(CM_ENTRIES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FAILED = 2'd2,
        DRAIN  = 2'd3
    } cm_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 exp_hit;
        logic [CM_AWIDTH-1:0] exp_addr;
    } cm_stage_t;

endpackage

// File: rtl/arf070b144e1r1w0cbbeheaa4acw_bcam_match_encoder.sv
// Combinational decode of a CAM match vector: any-hit, lowest set index,
// more-than-one-hit, and exact one-hot equality against an expected entry.
module arf070b144e1r1w0cbbeheaa4acw_bcam_match_encoder #(
    parameter int RF_ENTRIES = 144,
    parameter int RF_AWIDTH  = $clog2(RF_ENTRIES)
) (
    input  logic [RF_ENTRIES-1:0] match,
    input  logic [RF_AWIDTH-1:0]  exp_addr,
    output logic                  any_hit,
    output logic [RF_AWIDTH-1:0]  low_addr,
    output logic                  multi_hit,
    output logic                  onehot_eq
);

    logic [RF_ENTRIES-1:0] onehot;
    logic                  seen;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        onehot    = '0;
        low_addr  = '0;
        multi_hit = 1'b0;
        seen      = 1'b0;
        // Descending scan so the last write leaves the lowest set index.
        for (int i = RF_ENTRIES - 1; i >= 0; i--) begin
            onehot[i] = (RF_AWIDTH'(i) == exp_addr);
            if (match[i]) begin
                low_addr  = RF_AWIDTH'(i);
                multi_hit = multi_hit | seen;
                seen      = 1'b1;
            end
        end
    end

    assign any_hit   = |match;
    assign onehot_eq = (match == onehot);

endmodule

// File: rtl/blk_619ab8.sv
// BCAM MBIST output handler: delays compare expectations by the match latency and checks returned vectors.
// Define ARF070B144E1R1W0CBBEHEAA4ACW_CM_DIAG_EN to build the fail-address, count and multihit diagnostics.
module blk_619ab8
    import arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_pkg::*;
#(
    parameter int RF_ENTRIES = CM_ENTRIES,
    parameter int RF_AWIDTH  = $clog2(RF_ENTRIES),
    parameter int CM_LATENCY = 2,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                  bist_clk,
    input  logic                  rst_b,
    input  logic                  BIST_CM_MODE_RF_IN,
    input  logic                  BIST_CM_EN_RF_IN,
    input  logic                  BIST_CM_EXP_HIT_RF_IN,
    input  logic [RF_AWIDTH-1:0]  BIST_CM_EXP_ADDR_RF_IN,
    input  logic                  BIST_CLEAR_RF_IN,
    input  logic [RF_ENTRIES-1:0] CM_MATCH_RF_IN,
    output logic                  BIST_CM_FAIL_RF_OUT,
    output logic                  BIST_CM_FAIL_STICKY_RF_OUT,
    output logic                  BIST_CM_MULTIHIT_RF_OUT,
    output logic                  BIST_CM_BUSY_RF_OUT,
    output logic [RF_AWIDTH-1:0]  BIST_CM_FAIL_ADDR_RF_OUT,
    output logic [RF_AWIDTH-1:0]  BIST_CM_ACT_ADDR_RF_OUT,
    output logic [FCNT_WIDTH-1:0] BIST_CM_FAIL_CNT_RF_OUT
);

    cm_state_t             state, state_nxt;
    cm_stage_t             pipe [CM_LATENCY];
    cm_stage_t             chk;
    logic                  busy, enter_run, iss, chk_fail;
    logic                  fail_q, sticky_q;
    logic                  enc_any, enc_multi, enc_eq;
    logic [RF_AWIDTH-1:0]  enc_low;

    assign chk = pipe[CM_LATENCY-1];

    arf070b144e1r1w0cbbeheaa4acw_bcam_match_encoder #(
        .RF_ENTRIES (RF_ENTRIES),
        .RF_AWIDTH  (RF_AWIDTH)
    ) u_enc (
        .match     (CM_MATCH_RF_IN),
        .exp_addr  (chk.exp_addr),
        .any_hit   (enc_any),
        .low_addr  (enc_low),
        .multi_hit (enc_multi),
        .onehot_eq (enc_eq)
    );

    assign chk_fail  = chk.valid & (chk.exp_hit ? ~enc_eq : enc_any);
    assign enter_run = BIST_CM_MODE_RF_IN & ((state == IDLE) | (state == DRAIN));
    assign iss       = BIST_CM_EN_RF_IN & BIST_CM_MODE_RF_IN & ((state != IDLE) | enter_run);

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CM_LATENCY; i++) busy = busy | pipe[i].valid;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (BIST_CM_MODE_RF_IN) state_nxt = RUN;
            RUN: begin
                if (chk_fail)                 state_nxt = FAILED;
                else if (!BIST_CM_MODE_RF_IN) state_nxt = busy ? DRAIN : IDLE;
            end
            // A fail landing on the clear cycle keeps the block in FAILED.
            FAILED:  if (BIST_CLEAR_RF_IN && !chk_fail) state_nxt = BIST_CM_MODE_RF_IN ? RUN : IDLE;
            DRAIN: begin
                if (chk_fail)                state_nxt = FAILED;
                else if (BIST_CM_MODE_RF_IN) state_nxt = RUN;
                else if (!busy)              state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            fail_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fail_q <= chk_fail;
            if (BIST_CLEAR_RF_IN) sticky_q <= chk_fail;
            else if (chk_fail)    sticky_q <= 1'b1;
        end
    end

    // NOTE: the pipe is reset (not just its valids) so a reset mid-run leaves no stale expectation.
    always_ff @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < CM_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: iss, exp_hit: BIST_CM_EXP_HIT_RF_IN, exp_addr: BIST_CM_EXP_ADDR_RF_IN};
            for (int i = 1; i < CM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign BIST_CM_FAIL_RF_OUT        = fail_q;
    assign BIST_CM_FAIL_STICKY_RF_OUT = sticky_q;
    assign BIST_CM_BUSY_RF_OUT        = busy;

`ifdef ARF070B144E1R1W0CBBEHEAA4ACW_CM_DIAG_EN
    logic                  multi_q, first_fail;
    logic [RF_AWIDTH-1:0]  fail_addr_q, act_addr_q;
    logic [FCNT_WIDTH-1:0] cnt_q;

    // Clear and fail together re-arm capture so this fail becomes the new first fail.
    assign first_fail = chk_fail & (~sticky_q | BIST_CLEAR_RF_IN);

    always_ff @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b) begin
            multi_q     <= 1'b0;
            fail_addr_q <= '0;
            act_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            if (BIST_CLEAR_RF_IN)            multi_q <= chk.valid & enc_multi;
            else if (chk.valid && enc_multi) multi_q <= 1'b1;

            if (first_fail) begin
                fail_addr_q <= chk.exp_addr;
                act_addr_q  <= enc_low;
            end else if (BIST_CLEAR_RF_IN) begin
                fail_addr_q <= '0;
                act_addr_q  <= '0;
            end

            if (BIST_CLEAR_RF_IN)              cnt_q <= chk_fail ? FCNT_WIDTH'(1) : '0;
            else if (chk_fail && cnt_q != '1) cnt_q <= cnt_q + FCNT_WIDTH'(1);
        end
    end

    assign BIST_CM_MULTIHIT_RF_OUT  = multi_q;
    assign BIST_CM_FAIL_ADDR_RF_OUT = fail_addr_q;
    assign BIST_CM_ACT_ADDR_RF_OUT  = act_addr_q;
    assign BIST_CM_FAIL_CNT_RF_OUT  = cnt_q;
`else
    logic unused_diag;
    assign unused_diag = ^{enc_low, enc_multi};

    assign BIST_CM_MULTIHIT_RF_OUT  = 1'b0;
    assign BIST_CM_FAIL_ADDR_RF_OUT = '0;
    assign BIST_CM_ACT_ADDR_RF_OUT  = '0;
    assign BIST_CM_FAIL_CNT_RF_OUT  = '0;
`endif

endmodule

// File: tb/tb_blk_619ab8.sv
// Bench for blk_619ab8: a due-cycle queue model checked every falling edge, plus directed scenarios
// with literal expectations. Diagnostic expectations follow ARF070B144E1R1W0CBBEHEAA4ACW_CM_DIAG_EN.
module tb_blk_619ab8;

    localparam int N   = 144;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int CW  = 8;

    logic          bist_clk = 1'b0;
    logic          rst_b    = 1'b1;
    logic          mode, en, exp_hit, clr;
    logic [AW-1:0] exp_addr;
    logic [N-1:0]  match;

    logic          fail_o, sticky_o, mh_o, busy_o;
    logic [AW-1:0] faddr_o, aaddr_o;
    logic [CW-1:0] cnt_o;

    always #5 bist_clk = ~bist_clk;

    blk_619ab8 #(
        .RF_ENTRIES (N),
        .RF_AWIDTH  (AW),
        .CM_LATENCY (LAT),
        .FCNT_WIDTH (CW)
    ) dut (
        .bist_clk                   (bist_clk),
        .rst_b                      (rst_b),
        .BIST_CM_MODE_RF_IN         (mode),
        .BIST_CM_EN_RF_IN           (en),
        .BIST_CM_EXP_HIT_RF_IN      (exp_hit),
        .BIST_CM_EXP_ADDR_RF_IN     (exp_addr),
        .BIST_CLEAR_RF_IN           (clr),
        .CM_MATCH_RF_IN             (match),
        .BIST_CM_FAIL_RF_OUT        (fail_o),
        .BIST_CM_FAIL_STICKY_RF_OUT (sticky_o),
        .BIST_CM_MULTIHIT_RF_OUT    (mh_o),
        .BIST_CM_BUSY_RF_OUT        (busy_o),
        .BIST_CM_FAIL_ADDR_RF_OUT   (faddr_o),
        .BIST_CM_ACT_ADDR_RF_OUT    (aaddr_o),
        .BIST_CM_FAIL_CNT_RF_OUT    (cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] bit_n(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Model: each accepted compare waits in a queue tagged with the cycle its match vector is due.
    typedef struct {
        int unsigned   due;
        logic          hit;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct {
        int unsigned   cyc;
        logic          fail;
        logic          sticky;
        logic          mh;
        logic          busy;
        logic [AW-1:0] faddr;
        logic [AW-1:0] aaddr;
        int unsigned   cnt;
    } model_t;

    exp_t   q[$];
    model_t m = '{default: 0};

    function automatic model_t step(input model_t cur);
        model_t       nx;
        logic         chk;
        exp_t         e;
        logic [N-1:0] want;
        nx      = cur;
        chk     = 1'b0;
        e       = '{default: 0};
        nx.cyc  = cur.cyc + 1;
        nx.fail = 1'b0;
        if (q.size() > 0 && q[0].due == nx.cyc) begin
            e       = q.pop_front();
            chk     = 1'b1;
            want    = e.hit ? (N'(1) << e.addr) : '0;
            nx.fail = (match != want);
        end
        if (clr) begin
            nx.sticky = 1'b0;
            nx.mh     = 1'b0;
            nx.cnt    = 0;
            nx.faddr  = '0;
            nx.aaddr  = '0;
        end
        if (chk && $countones(match) > 1) nx.mh = 1'b1;
        if (nx.fail) begin
            if (!nx.sticky) begin
                nx.faddr = e.addr;
                nx.aaddr = AW'(lowest(match));
            end
            nx.sticky = 1'b1;
            if (nx.cnt < 255) nx.cnt = nx.cnt + 1;
        end
        if (mode && en) q.push_back('{due: nx.cyc + LAT, hit: exp_hit, addr: exp_addr});
        nx.busy = (q.size() != 0);
        return nx;
    endfunction

    always @(posedge bist_clk or negedge rst_b) begin
        if (!rst_b) begin
            q.delete();
            m <= '{default: 0};
        end else begin
            m <= step(m);
        end
    end

    always @(negedge bist_clk) begin
        check("fail_pulse", {31'd0, fail_o}, {31'd0, m.fail});
        check("sticky", {31'd0, sticky_o}, {31'd0, m.sticky});
        check("busy", {31'd0, busy_o}, {31'd0, m.busy});
`ifdef ARF070B144E1R1W0CBBEHEAA4ACW_CM_DIAG_EN
        check("multihit", {31'd0, mh_o}, {31'd0, m.mh});
        check("fail_addr", {24'd0, faddr_o}, {24'd0, m.faddr});
        check("act_addr", {24'd0, aaddr_o}, {24'd0, m.aaddr});
        check("fail_cnt", {24'd0, cnt_o}, m.cnt);
`else
        check("multihit_tied", {31'd0, mh_o}, 32'd0);
        check("fail_addr_tied", {24'd0, faddr_o}, 32'd0);
        check("act_addr_tied", {24'd0, aaddr_o}, 32'd0);
        check("fail_cnt_tied", {24'd0, cnt_o}, 32'd0);
`endif
    end

    task automatic tick();
        @(posedge bist_clk);
        #1;
    endtask

    // Issue one compare, then present its match vector on the check cycle LAT edges later.
    task automatic cam_op(input logic hit, input logic [AW-1:0] addr, input logic [N-1:0] ret);
        en = 1'b1; exp_hit = hit; exp_addr = addr;
        tick();
        en = 1'b0;
        tick();
        match = ret;
        tick();
        match = '0;
    endtask

    task automatic diag(input string tag, input int mh, input int fa, input int aa, input int c);
`ifdef ARF070B144E1R1W0CBBEHEAA4ACW_CM_DIAG_EN
        check({tag, "_mh"}, {31'd0, mh_o}, mh);
        check({tag, "_faddr"}, {24'd0, faddr_o}, fa);
        check({tag, "_aaddr"}, {24'd0, aaddr_o}, aa);
        check({tag, "_cnt"}, {24'd0, cnt_o}, c);
`else
        check({tag, "_cnt_tied"}, {24'd0, cnt_o}, 32'd0);
`endif
    endtask

    initial begin
        mode = 1'b0; en = 1'b0; exp_hit = 1'b0; exp_addr = '0; clr = 1'b0; match = '0;
        #2 rst_b = 1'b0;
        repeat (3) tick();
        check("rst_fail", {31'd0, fail_o}, 32'd0);
        check("rst_sticky", {31'd0, sticky_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        diag("rst", 0, 0, 0, 0);
        rst_b = 1'b1;
        mode  = 1'b1;
        tick();

        // Matching hit: busy for the two in-flight cycles, no fail.
        en = 1'b1; exp_hit = 1'b1; exp_addr = 8'd37;
        tick();
        check("s1_busy_c1", {31'd0, busy_o}, 32'd1);
        en = 1'b0;
        tick();
        check("s1_busy_c2", {31'd0, busy_o}, 32'd1);
        match = bit_n(37);
        tick();
        match = '0;
        check("s1_busy_done", {31'd0, busy_o}, 32'd0);
        check("s1_no_fail", {31'd0, fail_o}, 32'd0);
        check("s1_no_sticky", {31'd0, sticky_o}, 32'd0);

        // Wrong entry hits.
        cam_op(1'b1, 8'd37, bit_n(38));
        check("s2_fail", {31'd0, fail_o}, 32'd1);
        check("s2_sticky", {31'd0, sticky_o}, 32'd1);
        diag("s2", 0, 37, 38, 1);
        tick();
        check("s2_pulse_end", {31'd0, fail_o}, 32'd0);

        // Expected miss returns two hits; then a second fail leaves diagnostics alone.
        clr = 1'b1; tick(); clr = 1'b0;
        cam_op(1'b0, 8'd99, bit_n(5) | bit_n(143));
        check("s3_fail", {31'd0, fail_o}, 32'd1);
        diag("s3a", 1, 99, 5, 1);
        cam_op(1'b1, 8'd10, '0);
        check("s3_fail2", {31'd0, fail_o}, 32'd1);
        diag("s3b", 1, 99, 5, 2);

        // Back-to-back failing compares: counter saturates, then a clear lands on the 301st fail.
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; exp_hit = 1'b1; exp_addr = 8'd0; match = '0;
        for (int i = 1; i <= 303; i++) begin
            if (i == 303) clr = 1'b1;
            tick();
            if (i == 302) diag("s4_sat", 0, 0, 0, 255);
        end
        clr = 1'b0;
        check("s4_clr_fail", {31'd0, fail_o}, 32'd1);
        check("s4_clr_sticky", {31'd0, sticky_o}, 32'd1);
        diag("s4_clr", 0, 0, 0, 1);
        en = 1'b0;
        repeat (3) tick();

        // Mode drops right after an issue: the compare still gets checked while draining.
        clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; exp_hit = 1'b0; exp_addr = 8'd0;
        tick();
        en = 1'b0; mode = 1'b0;
        tick();
        match = bit_n(7);
        tick();
        match = '0;
        check("s5_drain_fail", {31'd0, fail_o}, 32'd1);
        check("s5_drain_idle", {31'd0, busy_o}, 32'd0);
        tick();
        en = 1'b1; exp_hit = 1'b1; exp_addr = 8'd4; match = bit_n(9);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s5_ignored_busy", {31'd0, busy_o}, 32'd0);
            check("s5_ignored_fail", {31'd0, fail_o}, 32'd0);
        end
        en = 1'b0; match = '0;

        // Reset with a failing compare in flight.
        mode = 1'b1;
        tick();
        en = 1'b1; exp_hit = 1'b1; exp_addr = 8'd3;
        tick();
        en = 1'b0;
        check("s6_pre_sticky", {31'd0, sticky_o}, 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check("s6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("s6_rst_sticky", {31'd0, sticky_o}, 32'd0);
        diag("s6_rst", 0, 0, 0, 0);
        match = bit_n(4);
        repeat (2) tick();
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s6_no_ghost", {31'd0, fail_o}, 32'd0);
        end
        match = '0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
